// File: rtl/bcd_scan_display.sv
// BCD cascade counter fed by a mod-10 digit stream, with a multiplexed
// common-anode 7-segment scan output (active-low segments and anodes).
module bcd_scan_display #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  count,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] bcd_value,
    output logic        ovf,
    output logic        err
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [3:0]    r_units, r_prev, r_tens, r_hund, r_thou;
    logic [CW-1:0] r_scan_cnt;
    logic [1:0]    r_digit_sel;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_ovf, r_err;

    logic          w_wrap, w_scan_adv;
    logic          w_blank_thou, w_blank_hund, w_blank_tens;
    logic [6:0]    w_seg_next;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0: f_seg = 7'b1000000;
            4'd1: f_seg = 7'b1111001;
            4'd2: f_seg = 7'b0100100;
            4'd3: f_seg = 7'b0110000;
            4'd4: f_seg = 7'b0011001;
            4'd5: f_seg = 7'b0010010;
            4'd6: f_seg = 7'b0000010;
            4'd7: f_seg = 7'b1111000;
            4'd8: f_seg = 7'b0000000;
            4'd9: f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    // An out-of-range prev or units can never equal 9/0, so invalid values never wrap.
    assign w_wrap     = (r_prev == 4'd9) && (r_units == 4'd0);
    assign w_scan_adv = (r_scan_cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_units <= '0;
            r_prev  <= '0;
            r_tens  <= '0;
            r_hund  <= '0;
            r_thou  <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_units <= count;
            r_prev  <= r_units;
            r_err   <= r_err | (r_units > 4'd9);
            r_ovf   <= 1'b0;
            if (w_wrap) begin
                if (r_tens != 4'd9) begin
                    r_tens <= r_tens + 4'd1;
                end else begin
                    r_tens <= '0;
                    if (r_hund != 4'd9) begin
                        r_hund <= r_hund + 4'd1;
                    end else begin
                        r_hund <= '0;
                        if (r_thou != 4'd9) begin
                            r_thou <= r_thou + 4'd1;
                        end else begin
                            r_thou <= '0;
                            r_ovf  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= '0;
            r_an        <= 4'b1111;
            r_seg       <= 7'b1111111;
        end else begin
            r_scan_cnt <= w_scan_adv ? '0 : r_scan_cnt + CW'(1);
            if (w_scan_adv)
                r_digit_sel <= r_digit_sel + 2'd1;
            r_an  <= ~(4'b0001 << r_digit_sel);
            r_seg <= w_seg_next;
        end
    end

    assign w_blank_thou = BLANK_LZ && (r_thou == 4'd0);
    assign w_blank_hund = w_blank_thou && (r_hund == 4'd0);
    assign w_blank_tens = w_blank_hund && (r_tens == 4'd0);

    always_comb begin
        w_seg_next = 7'b1111111;
        case (r_digit_sel)
            2'd0: w_seg_next = (r_units > 4'd9) ? 7'b0111111 : f_seg(r_units);
            2'd1: w_seg_next = w_blank_tens ? 7'b1111111 : f_seg(r_tens);
            2'd2: w_seg_next = w_blank_hund ? 7'b1111111 : f_seg(r_hund);
            2'd3: w_seg_next = w_blank_thou ? 7'b1111111 : f_seg(r_thou);
            default: w_seg_next = 7'b1111111;
        endcase
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign bcd_value = {r_thou, r_hund, r_tens, r_units};
    assign ovf       = r_ovf;
    assign err       = r_err;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: reset, cascade, overflow, scan, invalid input, mid-op reset.
module tb_bcd_scan_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  count = 4'd0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd_value;
    logic        ovf, err;

    int n_cmp = 0;
    int n_bad = 0;
    int since_rst = 0;
    int ovf_hits = 0;

    bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .count(count), .seg(seg), .an(an),
        .bcd_value(bcd_value), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) since_rst = 0;
        else since_rst++;
        if (ovf) ovf_hits++;
    endtask

    task automatic drive(input logic [3:0] v);
        count = v;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        ovf_hits = 0;
    endtask

    task automatic count_reps(input int n);
        for (int r = 0; r < n; r++)
            for (int d = 0; d < 10; d++) drive(4'(d));
    endtask

    function automatic int cur_slot();
        return ((since_rst - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << cur_slot());
    endfunction

    task automatic test_reset();
        rst = 1'b1; count = 4'd5;
        step(); step(); step();
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an got %b exp 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg got %b exp 1111111", seg); end
        n_cmp++; if (bcd_value !== 16'h0000) begin n_bad++; $display("FAIL reset_bcd got %h exp 0000", bcd_value); end
        n_cmp++; if (err !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL reset_flags got err=%b ovf=%b exp 0 0", err, ovf); end
        rst = 1'b0;
        step();
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL release_an got %b exp 1110", an); end
        n_cmp++; if (bcd_value !== 16'h0005) begin n_bad++; $display("FAIL release_units got %h exp 0005", bcd_value); end
    endtask

    task automatic test_cascade();
        do_reset();
        count_reps(1);
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0000) begin n_bad++; $display("FAIL cascade_pre_wrap got %h exp 0000", bcd_value); end
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0010) begin n_bad++; $display("FAIL cascade_first_wrap got %h exp 0010", bcd_value); end
        do_reset();
        count_reps(10);
        drive(4'd0);
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0100) begin n_bad++; $display("FAIL cascade_10_wraps got %h exp 0100", bcd_value); end
        n_cmp++; if (ovf_hits !== 0) begin n_bad++; $display("FAIL cascade_ovf got %0d pulses exp 0", ovf_hits); end
    endtask

    task automatic test_no_carry();
        do_reset();
        drive(4'd9); drive(4'd3); drive(4'd0); drive(4'd5);
        drive(4'd0); drive(4'd9); drive(4'd9); drive(4'd2); drive(4'd2);
        n_cmp++; if (bcd_value !== 16'h0002) begin n_bad++; $display("FAIL no_carry got %h exp 0002", bcd_value); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 999; i++) begin
            drive(4'd9);
            drive(4'd0);
        end
        drive(4'd9);
        n_cmp++; if (bcd_value !== 16'h9999) begin n_bad++; $display("FAIL ovf_preload got %h exp 9999", bcd_value); end
        n_cmp++; if (ovf_hits !== 0) begin n_bad++; $display("FAIL ovf_early got %0d pulses exp 0", ovf_hits); end
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h9990 || ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_units_zero got %h/%b exp 9990/0", bcd_value, ovf); end
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0000 || ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_wrap got %h/%b exp 0000/1", bcd_value, ovf); end
        drive(4'd0);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse_width got %b exp 0", ovf); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'b0100100;
        exp_seg[1] = 7'b0011001;
        exp_seg[2] = 7'b1111111;
        exp_seg[3] = 7'b1111111;
        do_reset();
        count_reps(4);
        drive(4'd0); drive(4'd1); drive(4'd2);
        drive(4'd2); drive(4'd2);
        n_cmp++; if (bcd_value !== 16'h0042) begin n_bad++; $display("FAIL scan_value got %h exp 0042", bcd_value); end
        for (int k = 0; k < 16; k++) begin
            drive(4'd2);
            n_cmp++; if (an !== exp_an()) begin n_bad++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, exp_an()); end
            n_cmp++; if (seg !== exp_seg[cur_slot()]) begin n_bad++; $display("FAIL scan_seg k=%0d got %b exp %b", k, seg, exp_seg[cur_slot()]); end
        end
    endtask

    task automatic test_invalid();
        do_reset();
        drive(4'd9);
        drive(4'hC);
        n_cmp++; if (bcd_value !== 16'h000C || err !== 1'b0) begin n_bad++; $display("FAIL inv_store got %h/%b exp 000c/0", bcd_value, err); end
        drive(4'd0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err_set got %b exp 1", err); end
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0000) begin n_bad++; $display("FAIL inv_no_wrap got %h exp 0000", bcd_value); end
        drive(4'd9); drive(4'd0); drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0010 || err !== 1'b1) begin n_bad++; $display("FAIL inv_then_wrap got %h/%b exp 0010/1", bcd_value, err); end
        drive(4'hC); drive(4'hC);
        for (int k = 0; k < 20; k++) begin
            drive(4'hC);
            if (cur_slot() == 0) begin
                n_cmp++; if (seg !== 7'b0111111) begin n_bad++; $display("FAIL inv_dash got %b exp 0111111", seg); end
            end else if (cur_slot() == 1) begin
                n_cmp++; if (seg !== 7'b1111001) begin n_bad++; $display("FAIL inv_tens got %b exp 1111001", seg); end
            end
        end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_sticky got %b exp 1", err); end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL inv_cleared got %b exp 0", err); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        count_reps(3);
        drive(4'd0); drive(4'd7); drive(4'd7);
        n_cmp++; if (bcd_value !== 16'h0037) begin n_bad++; $display("FAIL mid_value got %h exp 0037", bcd_value); end
        for (int g = 0; g < 32 && !(((since_rst + 1) % 16) >= 8 && ((since_rst + 1) % 16) <= 10); g++)
            drive(4'd7);
        drive(4'd9); drive(4'd0);
        n_cmp++; if (an !== 4'b1011 || bcd_value !== 16'h0030) begin n_bad++; $display("FAIL mid_pre got an=%b bcd=%h exp 1011/0030", an, bcd_value); end
        rst = 1'b1;
        drive(4'd0);
        rst = 1'b0;
        n_cmp++; if (bcd_value !== 16'h0000 || an !== 4'b1111 || seg !== 7'b1111111) begin n_bad++; $display("FAIL mid_rst got bcd=%h an=%b seg=%b exp 0000/1111/1111111", bcd_value, an, seg); end
        drive(4'd0);
        n_cmp++; if (bcd_value !== 16'h0000 || an !== 4'b1110) begin n_bad++; $display("FAIL mid_after got bcd=%h an=%b exp 0000/1110", bcd_value, an); end
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_no_carry();
        test_overflow();
        test_scan();
        test_invalid();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
